// File: rtl/reflet_hwi_reader_pkg.sv
// reflet_hwi_reader_pkg: shared constants for the hardware-info reader.
// State encoding, info register offsets, reg2 field positions, legal
// wordsize_code range and the configuration check helper.
package reflet_hwi_reader_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [1:0] REG_FREQ_LO = 2'd0;
  localparam logic [1:0] REG_FREQ_HI = 2'd1;
  localparam logic [1:0] REG_CFG     = 2'd2;
  localparam logic [1:0] REG_INFO2   = 2'd3;
  localparam int CFG_WS_LSB = 0;
  localparam int CFG_WS_MSB = 2;
  localparam int CFG_PE_LSB = 3;
  localparam int CFG_PE_MSB = 7;
  localparam logic [2:0] WS_MIN = 3'd1;
  localparam logic [2:0] WS_MAX = 3'd5;
  function automatic logic cfg_bad(input logic [15:0] freq, input logic [2:0] ws);
    return freq == 16'd0 || ws < WS_MIN || ws > WS_MAX;
  endfunction
endpackage

// File: rtl/reflet_us_ticker.sv
// reflet_us_ticker: one-cycle tick every i_period enabled cycles.
// i_clk/i_rst_n clock and async active-low reset, i_enable runs the count
// (cleared when low), i_period cycles per tick, o_tick registered pulse.
module reflet_us_ticker (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  output logic        o_tick
);
  logic [15:0] r_count;
  logic        w_hit;
  assign w_hit = r_count == i_period - 16'd1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_count <= '0;
      o_tick  <= 1'b0;
    end else begin
      r_count <= (i_enable && !w_hit) ? r_count + 16'd1 : 16'd0;
      o_tick  <= i_enable && w_hit;
    end
endmodule

// File: rtl/reflet_hwi_reader.sv
// reflet_hwi_reader: reads the four hardware-info registers over the
// peripheral bus and publishes decoded, checked configuration plus a 1 us tick.
// Ports: i_clk, i_rst_n (async active-low), i_start (rescan from DONE),
// o_bus_req/i_bus_gnt arbitration, o_addr/o_rd_en/i_data_in read port,
// o_clk_freq_mhz/o_wordsize_code/o_periph_en/o_info2 decoded info,
// o_valid/o_error status, o_us_tick microsecond pulse.
module reflet_hwi_reader
  import reflet_hwi_reader_pkg::*;
#(
  parameter int                        WORDSIZE       = 16,
  parameter int                        BASE_ADDR_SIZE = 16,
  parameter logic [BASE_ADDR_SIZE-1:0] BASE_ADDR      = 16'hFF00
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  output logic                      o_bus_req,
  input  logic                      i_bus_gnt,
  output logic [BASE_ADDR_SIZE-1:0] o_addr,
  output logic                      o_rd_en,
  input  logic [WORDSIZE-1:0]       i_data_in,
  output logic [15:0]               o_clk_freq_mhz,
  output logic [2:0]                o_wordsize_code,
  output logic [4:0]                o_periph_en,
  output logic [7:0]                o_info2,
  output logic                      o_valid,
  output logic                      o_error,
  output logic                      o_us_tick
);
  logic [2:0] r_state, w_next;
  logic [1:0] r_idx, w_next_idx;
  logic [7:0] r_shadow [4];
  logic       w_bus;
  logic       w_unused_data;
  assign w_unused_data = ^i_data_in[WORDSIZE-1:8];
  // idx restarts only when a new scan begins; a lost grant keeps it so the
  // interrupted register is re-read.
  always_comb begin
    w_next     = r_state;
    w_next_idx = r_idx;
    case (r_state)
      S_IDLE: begin
        w_next     = S_REQ;
        w_next_idx = 2'd0;
      end
      S_REQ:     w_next = i_bus_gnt ? S_ISSUE : S_REQ;
      S_ISSUE:   w_next = i_bus_gnt ? S_CAPTURE : S_REQ;
      S_CAPTURE: begin
        w_next     = !i_bus_gnt ? S_REQ : (r_idx == REG_INFO2) ? S_CHECK : S_ISSUE;
        w_next_idx = (i_bus_gnt && r_idx != REG_INFO2) ? r_idx + 2'd1 : r_idx;
      end
      S_CHECK:   w_next = S_DONE;
      S_DONE: begin
        w_next     = i_start ? S_REQ : S_DONE;
        w_next_idx = 2'd0;
      end
      default:   w_next = S_IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they line up with it.
  assign w_bus = w_next == S_ISSUE || w_next == S_CAPTURE;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_idx           <= 2'd0;
      r_shadow        <= '{default: '0};
      o_bus_req       <= 1'b0;
      o_addr          <= '0;
      o_rd_en         <= 1'b0;
      o_clk_freq_mhz  <= '0;
      o_wordsize_code <= '0;
      o_periph_en     <= '0;
      o_info2         <= '0;
      o_valid         <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_idx     <= w_next_idx;
      o_bus_req <= w_bus || w_next == S_REQ;
      o_rd_en   <= w_bus;
      o_addr    <= w_bus ? BASE_ADDR + {{(BASE_ADDR_SIZE-2){1'b0}}, w_next_idx} : '0;
      if (r_state == S_CAPTURE && i_bus_gnt)
        r_shadow[r_idx] <= i_data_in[7:0];
      if (r_state == S_CHECK) begin
        o_clk_freq_mhz  <= {r_shadow[REG_FREQ_HI], r_shadow[REG_FREQ_LO]};
        o_wordsize_code <= r_shadow[REG_CFG][CFG_WS_MSB:CFG_WS_LSB];
        o_periph_en     <= r_shadow[REG_CFG][CFG_PE_MSB:CFG_PE_LSB];
        o_info2         <= r_shadow[REG_INFO2];
        o_error         <= cfg_bad({r_shadow[REG_FREQ_HI], r_shadow[REG_FREQ_LO]},
                                   r_shadow[REG_CFG][CFG_WS_MSB:CFG_WS_LSB]);
        o_valid         <= 1'b1;
      end else if (r_state == S_DONE && i_start)
        o_valid <= 1'b0;
    end
  reflet_us_ticker u_ticker (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (o_valid && !o_error),
    .i_period (o_clk_freq_mhz),
    .o_tick   (o_us_tick)
  );
endmodule

// File: tb/tb_reflet_hwi_reader.sv
// tb_reflet_hwi_reader: randomized scans against a behavioural bus/info model.
module tb_reflet_hwi_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, gnt = 1'b1;
  logic        bus_req, rd_en, valid, error, us_tick;
  logic [15:0] addr, data, cfm;
  logic [2:0]  wsc;
  logic [4:0]  pe;
  logic [7:0]  info2;
  logic [7:0]  mem [4];
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign data = rd_en ? {8'hE7, mem[addr[1:0]]} : 16'hBAD0;
  reflet_hwi_reader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_bus_req(bus_req),
    .i_bus_gnt(gnt), .o_addr(addr), .o_rd_en(rd_en), .i_data_in(data),
    .o_clk_freq_mhz(cfm), .o_wordsize_code(wsc), .o_periph_en(pe),
    .o_info2(info2), .o_valid(valid), .o_error(error), .o_us_tick(us_tick)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  // kick: 1 = release reset, 2 = pulse start from DONE
  task automatic scan(input int kick, input logic [7:0] d0, d1, d2, d3,
                      input bit stall, input bit mid_start);
    logic [15:0] exp_a [$];
    logic [15:0] f;
    int g, v, sc, rd, n;
    bit stalled, bad;
    mem = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      repeat ((stall && i == 2) ? 4 : 2) exp_a.push_back(16'hFF00 + 16'(i));
    end
    g = -1; v = -1; sc = 0; rd = 0; stalled = 0;
    if (kick == 1) rst_n = 1'b1;
    else start = 1'b1;
    for (int c = 0; c < 300 && v < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sc > 0) begin
        sc--;
        if (sc == 0) gnt = 1'b1;
      end
      if (c == 0) check("stale_valid", valid, 0);
      if (bus_req && !rd_en && gnt && g < 0) g = c;
      if (rd_en) begin
        check("addr", addr, rd < exp_a.size() ? exp_a[rd] : 16'h0);
        rd++;
        if (stall && !stalled && rd == 6) begin
          gnt = 1'b0;
          sc = 3;
          stalled = 1;
        end
        if (mid_start && rd == 3) start = 1'b1;
      end
      if (valid) v = c;
    end
    check("valid_seen", valid, 1);
    check("reads", rd, exp_a.size());
    check("req_lat", g, 0);
    check("valid_lat", v - g, stall ? 15 : 10);
    check("bus_req_idle", bus_req, 0);
    check("rd_en_idle", rd_en, 0);
    check("addr_idle", addr, 0);
    f = {d1, d0};
    bad = f == 16'd0 || d2[2:0] == 3'd0 || d2[2:0] > 3'd5;
    check("clk_freq", cfm, f);
    check("wordsize", wsc, d2[2:0]);
    check("periph_en", pe, d2[7:3]);
    check("info2", info2, d3);
    check("error", error, bad);
    check("tick_at_valid", us_tick, 0);
    n = bad ? 40 : 2 * int'(f) + 3;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("us_tick", us_tick, bad ? 0 : (k % int'(f) == 0));
    end
  endtask
  initial begin
    logic [7:0] a, b2, b3;
    repeat (3) @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_addr", addr, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_freq", cfm, 0);
    check("rst_ws", wsc, 0);
    check("rst_pe", pe, 0);
    check("rst_info2", info2, 0);
    check("rst_valid", valid, 0);
    check("rst_error", error, 0);
    check("rst_tick", us_tick, 0);
    scan(1, 8'h32, 8'h00, 8'h53, 8'hA5, 0, 0);
    scan(2, 8'h10, 8'h00, 8'h2A, 8'h3C, 1, 0);
    scan(2, 8'h00, 8'h00, 8'h53, 8'h11, 0, 0);
    scan(2, 8'h20, 8'h00, 8'hF6, 8'h5A, 0, 1);
    scan(2, 8'h01, 8'h00, 8'h0B, 8'h00, 0, 0);
    scan(2, 8'h00, 8'h01, 8'h09, 8'hC3, 0, 0);
    for (int r = 0; r < 6; r++) begin
      a  = 8'($urandom_range(0, 24));
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      scan(2, a, 8'h00, b2, b3, 0, 0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !rd_en; c++) @(negedge clk);
    check("issue_seen", rd_en, 1);
    check("issue_addr", addr, 16'hFF00);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bus_req", bus_req, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_addr", addr, 0);
    check("abort_valid", valid, 0);
    check("abort_freq", cfm, 0);
    @(negedge clk);
    scan(1, 8'h0A, 8'h00, 8'h0D, 8'h77, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reflet_hwi_reader.md
# reflet_hwi_reader

Bus-side initiator that reads the hardware-info register window of the peripheral block and turns it into decoded, registered configuration signals for other hardware. After reset, and on request, it arbitrates for the peripheral bus, reads the four info registers in order, checks them, and publishes the result. It also generates a 1 µs tick from the decoded clock frequency. It sits beside the CPU on the peripheral bus and feeds timing-dependent logic such as baud generators and watchdogs.

## Interface
- wordsize, 16, peripheral data bus width; only bits [7:0] of each read are used
- base_addr_size, 16, peripheral address width
- base_addr, 16'hFF00, address of info register 0; registers 0..3 are at base_addr..base_addr+3

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- start  in  1  single-cycle rescan request
- bus_req  out  1  bus request to the arbiter
- bus_gnt  in  1  bus grant; may drop at any cycle
- addr  out  base_addr_size  read address
- rd_en  out  1  read strobe
- data_in  in  wordsize  read data; sampled one cycle after addr/rd_en are driven
- clk_freq_mhz  out  16  {reg1, reg0}
- wordsize_code  out  3  reg2[2:0]
- periph_en  out  5  reg2[7:3] = {pwm, uart, timer, gpio, exti}
- info2  out  8  reg3, raw
- valid  out  1  outputs are coherent and checked
- error  out  1  check failed; qualified by valid
- us_tick  out  1  one-cycle pulse every clk_freq_mhz cycles

## Operation
- States: IDLE, REQ, ISSUE, CAPTURE, CHECK, DONE. Index idx[1:0] selects the register.
- After reset is released, the block goes to REQ automatically. No start pulse is needed.
- IDLE is entered only from reset. The first clock after reset leaves it for REQ.
- REQ: bus_req=1. On bus_gnt=1, go to ISSUE with idx=0.
- ISSUE: addr=base_addr+idx and rd_en=1. Go to CAPTURE.
- CAPTURE: addr is held and rd_en=1. data_in[7:0] is latched into shadow register idx.
  - idx<3: idx+1 and return to ISSUE.
  - idx=3: go to CHECK.
- Loss of grant: if bus_gnt=0 in ISSUE or CAPTURE, nothing is latched and the block returns to REQ with idx kept. The interrupted register is re-read from ISSUE once granted again.
- bus_req stays high from REQ through CAPTURE of idx=3, and falls in CHECK.
- CHECK: shadow registers are copied to the outputs.
  - error=1 if clk_freq_mhz==0 or wordsize_code is 0 or greater than 5.
  - Go to DONE with valid=1.
- DONE: holds until start=1. Then valid is cleared that same edge and the block goes to REQ.
- start is ignored in every state except DONE.
- Outputs keep their previous values during a rescan. valid=0 marks them as stale.
- us_tick:
  - A 16-bit counter runs only while valid=1 and error=0, and is cleared otherwise.
  - us_tick=1 when count==clk_freq_mhz-1, and the count wraps to 0 at that point.
  - For clk_freq_mhz=1, us_tick is high every enabled cycle.
- addr=0 and rd_en=0 whenever the block is outside ISSUE/CAPTURE.

## Timing
- Reset values: bus_req=0, addr=0, rd_en=0, clk_freq_mhz=0, wordsize_code=0, periph_en=0, info2=0, valid=0, error=0, us_tick=0, counter=0.
- All outputs are registered. Asserting reset mid-scan aborts immediately to the reset values.
- Uninterrupted scan: grant is seen in REQ at cycle G.
  - The reads occupy cycles G+1..G+8, as ISSUE/CAPTURE pairs.
  - CHECK is at G+9, and valid rises at G+10.
- Startup: REQ is entered 1 cycle after reset release.
- First us_tick: exactly clk_freq_mhz cycles after valid rises.

## Structure
- A shared package holds:
  - state encoding
  - register offsets 0..3
  - bit positions of the reg2 fields
  - the legal wordsize_code range 1..5
- One natural sub-module: reflet_us_ticker. Inputs are clk, reset, enable and period[15:0]; output is tick. It is reusable by other timing blocks.
- The FSM, shadow registers and check logic stay in the top module.

## Test plan
- Reset release with gnt tied high; bus returns 0x32, 0x00, 0x53, 0xA5 → at G+10: valid=1, error=0, clk_freq_mhz=50, wordsize_code=3, periph_en=5'b01010, info2=0xA5. us_tick pulses every 50 cycles.
- Grant dropped for 3 cycles during CAPTURE of idx=2 → reg2 is re-read after re-grant. Final values are correct, and total latency grows by the stall.
- Bus returns reg0=reg1=0 → valid=1, error=1, us_tick never pulses.
- wordsize_code=6 with a valid frequency → error=1.
- start pulsed mid-scan → ignored; exactly 8 reads occur. start pulsed in DONE with new data 0x01, 0x00 → valid drops for the rescan, then clk_freq_mhz=1 and us_tick is high every cycle.
- Reset asserted during ISSUE → bus_req, rd_en, addr and valid are 0 immediately. After release, a fresh scan starts from idx=0.
